axi_from_mem_initiator: RTL and testbench

- Initiator-side bridge: accepts the memory island's req/gnt/rvalid word interface and issues single-beat AXI4 transactions on one manager port.
- Lets memory-island-side masters (DMA front-ends, narrow cores) reach AXI subordinates.
- Returns responses to the mem port strictly in request order, for both reads and writes.

---
 rtl/axi_from_mem_pkg.sv | 87 ++++++++
 rtl/axi_from_mem_order_fifo.sv | 55 +++++
 rtl/axi_from_mem_initiator.sv | 139 +++++++++++++
 tb/tb_axi_from_mem_initiator.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_from_mem_pkg.sv
// Shared AXI4 field constants, channel types and helpers for the mem-to-AXI initiator bridge.
package axi_from_mem_pkg;

  localparam int unsigned AxiAddrWidth = 32;
  localparam int unsigned AxiDataWidth = 64;
  localparam int unsigned AxiIdWidth   = 4;
  localparam int unsigned AxiUserWidth = 1;

  localparam logic [3:0] CacheModifiable = 4'b0010;
  localparam logic [1:0] BurstIncr       = 2'b01;

  function automatic logic [2:0] axi_size(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic                    lock;
    logic [3:0]              cache;
    logic [2:0]              prot;
    logic [3:0]              qos;
    logic [3:0]              region;
    logic [5:0]              atop;
    logic [AxiUserWidth-1:0] user;
  } mem_axi_aw_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic                    lock;
    logic [3:0]              cache;
    logic [2:0]              prot;
    logic [3:0]              qos;
    logic [3:0]              region;
    logic [AxiUserWidth-1:0] user;
  } mem_axi_ar_chan_t;

  typedef struct packed {
    logic [AxiDataWidth-1:0]   data;
    logic [AxiDataWidth/8-1:0] strb;
    logic                      last;
    logic [AxiUserWidth-1:0]   user;
  } mem_axi_w_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [1:0]              resp;
    logic [AxiUserWidth-1:0] user;
  } mem_axi_b_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiDataWidth-1:0] data;
    logic [1:0]              resp;
    logic                    last;
    logic [AxiUserWidth-1:0] user;
  } mem_axi_r_chan_t;

  typedef struct packed {
    mem_axi_aw_chan_t aw;
    logic             aw_valid;
    mem_axi_w_chan_t  w;
    logic             w_valid;
    logic             b_ready;
    mem_axi_ar_chan_t ar;
    logic             ar_valid;
    logic             r_ready;
  } mem_axi_req_t;

  typedef struct packed {
    logic             aw_ready;
    logic             ar_ready;
    logic             w_ready;
    logic             b_valid;
    mem_axi_b_chan_t  b;
    logic             r_valid;
    mem_axi_r_chan_t  r;
  } mem_axi_rsp_t;

endpackage

// File: rtl/axi_from_mem_order_fifo.sv
// 1-bit FIFO recording the type (1 = write) of each in-flight transaction in issue order.
module axi_from_mem_order_fifo #(
  parameter  int unsigned Depth    = 4,
  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic                data_i,
  input  logic                pop_i,
  output logic                full_o,
  output logic                empty_o,
  output logic                head_o,
  output logic [CntWidth-1:0] usage_o
);

  localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Depth - 1);
  localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);

  logic [Depth-1:0]    mem_q;
  logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0] usage_q;
  logic                do_push, do_pop;

  assign full_o  = (usage_q == DepthCnt);
  assign empty_o = (usage_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign usage_o = usage_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrWidth'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrWidth'(1);
      end
      case ({do_push, do_pop})
        2'b10:   usage_q <= usage_q + CntWidth'(1);
        2'b01:   usage_q <= usage_q - CntWidth'(1);
        default: usage_q <= usage_q;
      endcase
    end
  end

endmodule

// File: rtl/axi_from_mem_initiator.sv
// Bridges a req/gnt/rvalid memory port onto single-beat AXI4 transactions,
// returning read and write responses strictly in request order.
module axi_from_mem_initiator
  import axi_from_mem_pkg::*;
#(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned IdWidth        = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter type         axi_req_t      = mem_axi_req_t,
  parameter type         axi_rsp_t      = mem_axi_rsp_t
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   mem_req_i,
  output logic                   mem_gnt_o,
  input  logic [AddrWidth-1:0]   mem_addr_i,
  input  logic                   mem_we_i,
  input  logic [DataWidth-1:0]   mem_wdata_i,
  input  logic [DataWidth/8-1:0] mem_strb_i,
  output logic                   mem_rvalid_o,
  output logic [DataWidth-1:0]   mem_rdata_o,
  output logic                   mem_err_o,
  output axi_req_t               axi_req_o,
  input  axi_rsp_t               axi_rsp_i
);

  localparam int unsigned         CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0] MaxCnt   = CntWidth'(MaxOutstanding);

  logic                   ar_valid_q, aw_valid_q, w_valid_q;
  logic [AddrWidth-1:0]   ar_addr_q, aw_addr_q;
  logic [DataWidth-1:0]   w_data_q;
  logic [DataWidth/8-1:0] w_strb_q;
  logic [CntWidth-1:0]    cnt_q;

  logic gnt, r_ready, b_ready, r_hs, b_hs, rsp_hs;
  logic fifo_full, fifo_empty, fifo_head;
  logic [CntWidth-1:0] fifo_usage;

  // Target registers must already be empty: a slot freed this cycle is reused next cycle.
  assign gnt = !rst_i && mem_req_i && (cnt_q < MaxCnt) &&
               (mem_we_i ? (!aw_valid_q && !w_valid_q) : !ar_valid_q);
  assign mem_gnt_o = gnt;

  assign r_ready = !fifo_empty && !fifo_head;
  assign b_ready = !fifo_empty &&  fifo_head;
  assign r_hs    = axi_rsp_i.r_valid && r_ready;
  assign b_hs    = axi_rsp_i.b_valid && b_ready;
  assign rsp_hs  = r_hs || b_hs;

  assign mem_rvalid_o = rsp_hs;
  assign mem_rdata_o  = r_hs ? axi_rsp_i.r.data : '0;
  assign mem_err_o    = (r_hs && axi_rsp_i.r.resp[1]) || (b_hs && axi_rsp_i.b.resp[1]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ar_valid_q <= 1'b0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_addr_q  <= '0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      cnt_q      <= '0;
    end else begin
      if (gnt && !mem_we_i) begin
        ar_valid_q <= 1'b1;
        ar_addr_q  <= mem_addr_i;
      end else if (axi_rsp_i.ar_ready) begin
        ar_valid_q <= 1'b0;
      end
      if (gnt && mem_we_i) begin
        aw_valid_q <= 1'b1;
        aw_addr_q  <= mem_addr_i;
        w_valid_q  <= 1'b1;
        w_data_q   <= mem_wdata_i;
        w_strb_q   <= mem_strb_i;
      end else begin
        if (axi_rsp_i.aw_ready) aw_valid_q <= 1'b0;
        if (axi_rsp_i.w_ready)  w_valid_q  <= 1'b0;
      end
      case ({gnt, rsp_hs})
        2'b10:   cnt_q <= cnt_q + CntWidth'(1);
        2'b01:   cnt_q <= cnt_q - CntWidth'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_comb begin
    axi_req_o             = '0;
    axi_req_o.aw.addr     = aw_addr_q;
    axi_req_o.aw.size     = axi_size(DataWidth);
    axi_req_o.aw.burst    = BurstIncr;
    axi_req_o.aw.cache    = CacheModifiable;
    axi_req_o.aw_valid    = aw_valid_q;
    axi_req_o.w.data      = w_data_q;
    axi_req_o.w.strb      = w_strb_q;
    axi_req_o.w.last      = 1'b1;
    axi_req_o.w_valid     = w_valid_q;
    axi_req_o.b_ready     = b_ready;
    axi_req_o.ar.addr     = ar_addr_q;
    axi_req_o.ar.size     = axi_size(DataWidth);
    axi_req_o.ar.burst    = BurstIncr;
    axi_req_o.ar.cache    = CacheModifiable;
    axi_req_o.ar_valid    = ar_valid_q;
    axi_req_o.r_ready     = r_ready;
  end

  axi_from_mem_order_fifo #(
    .Depth (MaxOutstanding)
  ) i_order_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (gnt),
    .data_i  (mem_we_i),
    .pop_i   (rsp_hs),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head),
    .usage_o (fifo_usage)
  );

  logic unused_sig;
  assign unused_sig = ^{fifo_full, axi_rsp_i.r.id, axi_rsp_i.r.user, axi_rsp_i.r.resp[0],
                        axi_rsp_i.b.id, axi_rsp_i.b.user, axi_rsp_i.b.resp[0], IdWidth[0]};

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (rst_i)
                   (axi_rsp_i.r_valid || axi_rsp_i.b_valid) |-> !fifo_empty)
    else $error("response valid with no transaction in flight");
  assert property (@(posedge clk_i) disable iff (rst_i) axi_rsp_i.r_valid |-> axi_rsp_i.r.last)
    else $error("rlast low on a single-beat read");
  assert property (@(posedge clk_i) disable iff (rst_i) cnt_q == fifo_usage)
    else $error("outstanding count disagrees with order FIFO occupancy");
`endif

endmodule

// File: tb/tb_axi_from_mem_initiator.sv
// Directed self-checking bench for axi_from_mem_initiator (AXI subordinate driven by hand).
module tb_axi_from_mem_initiator;
  import axi_from_mem_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         mem_req_i = 1'b0;
  logic         mem_gnt_o;
  logic [31:0]  mem_addr_i = '0;
  logic         mem_we_i = 1'b0;
  logic [63:0]  mem_wdata_i = '0;
  logic [7:0]   mem_strb_i = '0;
  logic         mem_rvalid_o;
  logic [63:0]  mem_rdata_o;
  logic         mem_err_o;
  mem_axi_req_t axi_req;
  mem_axi_rsp_t axi_rsp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  axi_from_mem_initiator #(
    .AddrWidth      (32),
    .DataWidth      (64),
    .IdWidth        (4),
    .MaxOutstanding (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .mem_req_i    (mem_req_i),
    .mem_gnt_o    (mem_gnt_o),
    .mem_addr_i   (mem_addr_i),
    .mem_we_i     (mem_we_i),
    .mem_wdata_i  (mem_wdata_i),
    .mem_strb_i   (mem_strb_i),
    .mem_rvalid_o (mem_rvalid_o),
    .mem_rdata_o  (mem_rdata_o),
    .mem_err_o    (mem_err_o),
    .axi_req_o    (axi_req),
    .axi_rsp_i    (axi_rsp)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic mem_drive(input logic req, input logic we, input logic [31:0] addr,
                           input logic [63:0] wdata, input logic [7:0] strb);
    mem_req_i = req; mem_we_i = we; mem_addr_i = addr; mem_wdata_i = wdata; mem_strb_i = strb;
  endtask

  task automatic r_drive(input logic valid, input logic [63:0] data, input logic [1:0] resp);
    axi_rsp.r_valid = valid; axi_rsp.r.data = data; axi_rsp.r.resp = resp; axi_rsp.r.last = 1'b1;
  endtask

  task automatic b_drive(input logic valid, input logic [1:0] resp);
    axi_rsp.b_valid = valid; axi_rsp.b.resp = resp;
  endtask

  initial begin
    logic [31:0] idx;
    logic [63:0] exp_d;
    logic        exp_g;
    logic [8:0]  gnt_fill;
    logic [5:0]  gnt_drain;
    gnt_fill  = 9'b001010101;
    gnt_drain = 6'b001010;

    axi_rsp = '0;
    axi_rsp.aw_ready = 1'b1; axi_rsp.ar_ready = 1'b1; axi_rsp.w_ready = 1'b1;
    r_drive(1'b0, '0, 2'b00);

    // reset state, request held high to show grant is suppressed
    step(); mem_drive(1'b1, 1'b0, 32'h0, '0, '0); #1;
    check("rst_gnt", mem_gnt_o, 0);
    check("rst_arvalid", axi_req.ar_valid, 0);
    check("rst_awvalid", axi_req.aw_valid, 0);
    check("rst_wvalid", axi_req.w_valid, 0);
    check("rst_rready", axi_req.r_ready, 0);
    check("rst_bready", axi_req.b_ready, 0);
    check("rst_rvalid", mem_rvalid_o, 0);
    check("rst_err", mem_err_o, 0);
    check("rst_cnt", dut.cnt_q, 0);
    step(); rst_i = 1'b0; mem_drive(1'b0, 1'b0, 32'h0, '0, '0);

    // single read
    step(); mem_drive(1'b1, 1'b0, 32'h100, '0, '0); #1;
    check("rd_gnt", mem_gnt_o, 1);
    step(); mem_drive(1'b0, 1'b0, 32'h0, '0, '0); #1;
    check("rd_arvalid", axi_req.ar_valid, 1);
    check("rd_araddr", axi_req.ar.addr, 32'h100);
    check("rd_arsize", axi_req.ar.size, 3);
    check("rd_arburst", axi_req.ar.burst, 1);
    check("rd_arcache", axi_req.ar.cache, 4'b0010);
    check("rd_arlen", axi_req.ar.len, 0);
    check("rd_rready", axi_req.r_ready, 1);
    check("rd_bready", axi_req.b_ready, 0);
    check("rd_rvalid_early", mem_rvalid_o, 0);
    step(); r_drive(1'b1, 64'hDEADBEEF_CAFEF00D, 2'b00); #1;
    check("rd_rvalid", mem_rvalid_o, 1);
    check("rd_rdata", mem_rdata_o, 64'hDEADBEEF_CAFEF00D);
    check("rd_err", mem_err_o, 0);
    check("rd_arvalid_clr", axi_req.ar_valid, 0);
    step(); r_drive(1'b0, '0, 2'b00); #1;
    check("rd_rvalid_end", mem_rvalid_o, 0);
    check("rd_cnt_end", dut.cnt_q, 0);

    // write with W stalled three cycles; second write waits for W to drain
    step(); axi_rsp.w_ready = 1'b0;
    mem_drive(1'b1, 1'b1, 32'h40, 64'h11223344_55667788, 8'h0F); #1;
    check("wr_gnt", mem_gnt_o, 1);
    step(); mem_drive(1'b1, 1'b1, 32'h48, 64'h99AABBCC_DDEEFF00, 8'hFF); #1;
    check("wr_gnt_blk1", mem_gnt_o, 0);
    check("wr_awvalid", axi_req.aw_valid, 1);
    check("wr_awaddr", axi_req.aw.addr, 32'h40);
    check("wr_wvalid", axi_req.w_valid, 1);
    check("wr_wstrb", axi_req.w.strb, 8'h0F);
    check("wr_wdata", axi_req.w.data, 64'h11223344_55667788);
    check("wr_wlast", axi_req.w.last, 1);
    check("wr_bready", axi_req.b_ready, 1);
    check("wr_rready", axi_req.r_ready, 0);
    step(); #1;
    check("wr_aw_done", axi_req.aw_valid, 0);
    check("wr_w_hold2", axi_req.w_valid, 1);
    check("wr_gnt_blk2", mem_gnt_o, 0);
    step(); #1;
    check("wr_w_hold3", axi_req.w_valid, 1);
    check("wr_gnt_blk3", mem_gnt_o, 0);
    step(); axi_rsp.w_ready = 1'b1; #1;
    check("wr_w_hold4", axi_req.w_valid, 1);
    check("wr_gnt_blk4", mem_gnt_o, 0);
    step(); b_drive(1'b1, 2'b00); #1;
    check("wr_w_done", axi_req.w_valid, 0);
    check("wr2_gnt", mem_gnt_o, 1);
    check("wr_bvalid", mem_rvalid_o, 1);
    check("wr_rdata0", mem_rdata_o, 0);
    check("wr_err0", mem_err_o, 0);
    step(); mem_drive(1'b0, 1'b0, 32'h0, '0, '0); b_drive(1'b0, 2'b00); #1;
    check("wr2_awaddr", axi_req.aw.addr, 32'h48);
    check("wr2_wstrb", axi_req.w.strb, 8'hFF);
    check("wr2_rvalid0", mem_rvalid_o, 0);
    check("wr2_cnt", dut.cnt_q, 1);
    step(); b_drive(1'b1, 2'b10); #1;
    check("wr2_rvalid", mem_rvalid_o, 1);
    check("wr2_slverr", mem_err_o, 1);
    check("wr2_rdata0", mem_rdata_o, 0);
    step(); b_drive(1'b0, 2'b00); #1;
    check("wr2_cnt_end", dut.cnt_q, 0);

    // six reads with R held off: AR slot reuse gives a grant every other cycle up to four
    idx = 0;
    for (int c = 0; c < 9; c++) begin
      step(); mem_drive(1'b1, 1'b0, 32'h1000 + idx * 8, '0, '0); #1;
      exp_g = gnt_fill[c];
      check($sformatf("fill_gnt%0d", c), mem_gnt_o, exp_g);
      if (c % 2 == 1 && c < 8)
        check($sformatf("fill_araddr%0d", c), axi_req.ar.addr, 32'h1000 + 32'((c - 1) / 2) * 8);
      if (exp_g) idx++;
    end
    check("fill_cnt4", dut.cnt_q, 4);
    for (int c = 0; c < 6; c++) begin
      step();
      if (c < 4) mem_drive(1'b1, 1'b0, 32'h1000 + idx * 8, '0, '0);
      else       mem_drive(1'b0, 1'b0, 32'h0, '0, '0);
      exp_d = 64'hA5A50000_00000000 | 64'(c);
      r_drive(1'b1, exp_d, 2'b00); #1;
      exp_g = gnt_drain[c];
      check($sformatf("drain_gnt%0d", c), mem_gnt_o, exp_g);
      check($sformatf("drain_rvalid%0d", c), mem_rvalid_o, 1);
      check($sformatf("drain_rdata%0d", c), mem_rdata_o, exp_d);
      if (c == 2) check("drain_araddr4", axi_req.ar.addr, 32'h1020);
      if (c == 4) check("drain_araddr5", axi_req.ar.addr, 32'h1028);
      if (exp_g) idx++;
    end
    step(); r_drive(1'b0, '0, 2'b00); #1;
    check("drain_rvalid_end", mem_rvalid_o, 0);
    check("drain_cnt_end", dut.cnt_q, 0);

    // write then read, subordinate offers R before B
    step(); mem_drive(1'b1, 1'b1, 32'h200, 64'h5, 8'hFF); #1;
    check("ord_wgnt", mem_gnt_o, 1);
    step(); mem_drive(1'b1, 1'b0, 32'h300, '0, '0); #1;
    check("ord_rgnt", mem_gnt_o, 1);
    check("ord_awvalid", axi_req.aw_valid, 1);
    step(); mem_drive(1'b0, 1'b0, 32'h0, '0, '0); #1;
    check("ord_arvalid", axi_req.ar_valid, 1);
    for (int c = 0; c < 2; c++) begin
      step(); r_drive(1'b1, 64'h01234567_89ABCDEF, 2'b00); #1;
      check($sformatf("ord_rready_hold%0d", c), axi_req.r_ready, 0);
      check($sformatf("ord_bready%0d", c), axi_req.b_ready, 1);
      check($sformatf("ord_rvalid_hold%0d", c), mem_rvalid_o, 0);
    end
    step(); b_drive(1'b1, 2'b00); #1;
    check("ord_b_first", mem_rvalid_o, 1);
    check("ord_b_rdata", mem_rdata_o, 0);
    check("ord_rready_b", axi_req.r_ready, 0);
    step(); b_drive(1'b0, 2'b00); #1;
    check("ord_r_second", mem_rvalid_o, 1);
    check("ord_r_rdata", mem_rdata_o, 64'h01234567_89ABCDEF);
    check("ord_rready", axi_req.r_ready, 1);
    step(); r_drive(1'b0, '0, 2'b00); #1;
    check("ord_cnt_end", dut.cnt_q, 0);

    // DECERR read
    step(); mem_drive(1'b1, 1'b0, 32'h400, '0, '0); #1;
    check("dec_gnt", mem_gnt_o, 1);
    step(); mem_drive(1'b0, 1'b0, 32'h0, '0, '0);
    step(); r_drive(1'b1, 64'hBAD, 2'b11); #1;
    check("dec_rvalid", mem_rvalid_o, 1);
    check("dec_err", mem_err_o, 1);
    check("dec_rdata", mem_rdata_o, 64'hBAD);
    step(); r_drive(1'b0, '0, 2'b00); #1;
    check("dec_err_clr", mem_err_o, 0);

    // reset with three reads outstanding and AR pending
    for (int c = 0; c < 5; c++) begin
      step(); mem_drive(1'b1, 1'b0, 32'h2000, '0, '0); #1;
      check($sformatf("rr_gnt%0d", c), mem_gnt_o, (c % 2 == 0));
    end
    step(); mem_drive(1'b0, 1'b0, 32'h0, '0, '0); axi_rsp.ar_ready = 1'b0; #1;
    check("rr_arvalid", axi_req.ar_valid, 1);
    check("rr_cnt3", dut.cnt_q, 3);
    check("rr_rready", axi_req.r_ready, 1);
    #2 rst_i = 1'b1; mem_drive(1'b1, 1'b0, 32'h2000, '0, '0); #1;
    check("rr_arvalid_async", axi_req.ar_valid, 0);
    check("rr_rready_async", axi_req.r_ready, 0);
    check("rr_gnt_async", mem_gnt_o, 0);
    check("rr_rvalid_async", mem_rvalid_o, 0);
    check("rr_cnt_async", dut.cnt_q, 0);
    step(); step(); rst_i = 1'b0; axi_rsp.ar_ready = 1'b1; mem_drive(1'b0, 1'b0, 32'h0, '0, '0);
    step(); mem_drive(1'b1, 1'b0, 32'h3000, '0, '0); #1;
    check("post_gnt", mem_gnt_o, 1);
    step(); mem_drive(1'b0, 1'b0, 32'h0, '0, '0); #1;
    check("post_araddr", axi_req.ar.addr, 32'h3000);
    check("post_cnt1", dut.cnt_q, 1);
    step(); r_drive(1'b1, 64'h0F0F0F0F_F0F0F0F0, 2'b00); #1;
    check("post_rvalid", mem_rvalid_o, 1);
    check("post_rdata", mem_rdata_o, 64'h0F0F0F0F_F0F0F0F0);
    step(); r_drive(1'b0, '0, 2'b00); #1;
    check("post_cnt_end", dut.cnt_q, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
